// File: rtl/wrapper_pkg.sv
// Shared types and defaults for the byte-wide wrapper host.
// Provides the host FSM state enum, byte width and default timing constants.
package wrapper_pkg;

   localparam int BYTE_W       = 8;
   localparam int N_BYTES_DEF  = 4;
   localparam int GOT_HIGH_DEF = 2;
   localparam int GOT_GAP_DEF  = 4;
   localparam int TIMEOUT_DEF  = 255;
   localparam int CNT_W        = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_RFI,
      S_SEND_REQ,
      S_SEND_REL,
      S_RECV_WAIT,
      S_RECV_HIGH,
      S_RECV_GAP,
      S_DONE
   } state_t;

endpackage

// File: rtl/wrapper_host_cnt.sv
// Loadable down-counter with a zero flag; stops at zero.
// Ports: clk, rst (sync, high), load, load_val[W], zero.
module wrapper_host_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - W'(1);
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/wrapper_host.sv
// Host side of the byte-wide wrapper: sends a word LSB first with a
// 4-phase data_ready/data_accepted handshake, then drains N_BYTES result
// bytes with got_data pulses and reassembles them into word_out.
// Ports: clk, rst (sync, high), start, word_in, ready_for_input,
//   data_accepted, buffer_ready, Bus_in -> data_ready, Bus_out,
//   got_data, word_out, busy, done, error (sticky timeout).
module wrapper_host
   import wrapper_pkg::*;
#(
   parameter int N_BYTES  = N_BYTES_DEF,
   parameter int GOT_HIGH = GOT_HIGH_DEF,
   parameter int GOT_GAP  = GOT_GAP_DEF,
   parameter int TIMEOUT  = TIMEOUT_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [BYTE_W*N_BYTES-1:0] word_in,
   input  logic                      ready_for_input,
   input  logic                      data_accepted,
   input  logic                      buffer_ready,
   input  logic [BYTE_W-1:0]         Bus_in,
   output logic                      data_ready,
   output logic [BYTE_W-1:0]         Bus_out,
   output logic                      got_data,
   output logic [BYTE_W*N_BYTES-1:0] word_out,
   output logic                      busy,
   output logic                      done,
   output logic                      error
);

   localparam int WORD_W = BYTE_W * N_BYTES;
   localparam int IDX_W  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N_BYTES - 1);
   localparam logic [CNT_W-1:0] TMO_LD =
      CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CNT_W-1:0] HIGH_LD = CNT_W'(GOT_HIGH - 1);
   localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GOT_GAP - 1);

   state_t             state;
   state_t             state_nx;
   logic [WORD_W-1:0]  tx_reg;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W-1:0]   tx_sel;
   logic [BYTE_W-1:0]  tx_byte;
   logic               last;
   logic               cnt_zero;
   logic               cnt_load;
   logic [CNT_W-1:0]   cnt_val;
   logic               tmo;
   logic               abort;

   assign last = (idx == LAST);
   assign tmo  = (TIMEOUT != 0) && cnt_zero;

   // One counter serves both got_data timing and the handshake
   // timeout; it is reloaded on every state change.
   wrapper_host_cnt #(
      .W (CNT_W)
   ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      abort    = 1'b0;
      unique case (state)
         S_IDLE:
            if (start) state_nx = S_WAIT_RFI;
         S_WAIT_RFI:
            if (ready_for_input) state_nx = S_SEND_REQ;
            else if (tmo)        abort    = 1'b1;
         S_SEND_REQ:
            if (data_accepted) state_nx = S_SEND_REL;
            else if (tmo)      abort    = 1'b1;
         S_SEND_REL:
            if (!data_accepted)
               state_nx = last ? S_RECV_WAIT : S_SEND_REQ;
            else if (tmo)
               abort = 1'b1;
         S_RECV_WAIT:
            if (buffer_ready) state_nx = S_RECV_HIGH;
            else if (tmo)     abort    = 1'b1;
         S_RECV_HIGH:
            if (cnt_zero) state_nx = S_RECV_GAP;
         S_RECV_GAP:
            if (cnt_zero)
               state_nx = last ? S_DONE : S_RECV_WAIT;
         S_DONE:
            state_nx = S_IDLE;
         default:
            state_nx = S_IDLE;
      endcase
      if (abort) state_nx = S_IDLE;
   end

   always_comb begin
      cnt_load = (state_nx != state);
      unique case (1'b1)
         (state_nx == S_RECV_HIGH): cnt_val = HIGH_LD;
         (state_nx == S_RECV_GAP):  cnt_val = GAP_LD;
         default:                   cnt_val = TMO_LD;
      endcase
      // Coming out of SEND_REL the next byte goes straight onto the bus.
      if (state == S_SEND_REL && !last)
         tx_sel = idx + IDX_W'(1);
      else
         tx_sel = idx;
      tx_byte = tx_reg[BYTE_W*tx_sel +: BYTE_W];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_reg     <= '0;
         idx        <= '0;
         data_ready <= 1'b0;
         Bus_out    <= '0;
         got_data   <= 1'b0;
         word_out   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         data_ready <= (state_nx == S_SEND_REQ);
         got_data   <= (state_nx == S_RECV_HIGH);
         done       <= (state_nx == S_DONE);
         busy       <= (state_nx != S_IDLE);
         if (state == S_IDLE && start) begin
            tx_reg <= word_in;
            idx    <= '0;
            error  <= 1'b0;
         end
         if (abort)
            error <= 1'b1;
         if (state_nx == S_SEND_REQ && state != S_SEND_REQ)
            Bus_out <= tx_byte;
         if (state == S_SEND_REL && !data_accepted)
            idx <= last ? '0 : idx + IDX_W'(1);
         if (state == S_RECV_WAIT && buffer_ready)
            word_out[BYTE_W*idx +: BYTE_W] <= Bus_in;
         if (state == S_RECV_GAP && cnt_zero && !last)
            idx <= idx + IDX_W'(1);
      end
   end

endmodule

// File: tb/tb_wrapper_host.sv
// Self-checking bench for wrapper_host with a cycle-level wrapper model.
// Ports: none; drives the DUT from tasks and compares against the model.
module tb_wrapper_host;

   localparam int NB = 4;
   localparam int GH = 2;
   localparam int GG = 4;
   localparam int TO = 255;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [31:0]   word_in;
   logic          ready_for_input;
   logic          data_accepted;
   logic          buffer_ready;
   logic [7:0]    Bus_in;
   logic          data_ready;
   logic [7:0]    Bus_out;
   logic          got_data;
   logic [31:0]   word_out;
   logic          busy;
   logic          done;
   logic          error;

   always #5 clk = ~clk;

   wrapper_host #(
      .N_BYTES  (NB),
      .GOT_HIGH (GH),
      .GOT_GAP  (GG),
      .TIMEOUT  (TO)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .word_in         (word_in),
      .ready_for_input (ready_for_input),
      .data_accepted   (data_accepted),
      .buffer_ready    (buffer_ready),
      .Bus_in          (Bus_in),
      .data_ready      (data_ready),
      .Bus_out         (Bus_out),
      .got_data        (got_data),
      .word_out        (word_out),
      .busy            (busy),
      .done            (done),
      .error           (error)
   );

   int total = 0;
   int bad   = 0;

   logic [7:0]  sent_q[$];
   int          got_w[$];
   int          got_g[$];
   int          dr_rises, dr_hi, drop_late, bus_unstable;
   int          done_cnt, first_dr, rfi_cyc, ran_out, hit_abort;
   logic        err_at_start;
   logic [31:0] word_at_done;

   // Expected byte i of a word, LSB first.
   function automatic logic [7:0] exp_byte(input logic [31:0] w,
                                           input int i);
      logic [31:0] s;
      s = w >> (8 * i);
      return s[7:0];
   endfunction

   function automatic int sent_bad(input logic [31:0] w);
      int m;
      m = (sent_q.size() != NB) ? 1 : 0;
      for (int i = 0; i < sent_q.size() && i < NB; i++)
         if (sent_q[i] !== exp_byte(w, i)) m++;
      return m;
   endfunction

   function automatic int width_bad();
      int m;
      m = (got_w.size() != NB) ? 1 : 0;
      foreach (got_w[i]) if (got_w[i] != GH) m++;
      return m;
   endfunction

   function automatic int gap_bad();
      int m;
      m = (got_g.size() != NB - 1) ? 1 : 0;
      foreach (got_g[i]) if (got_g[i] < GG) m++;
      return m;
   endfunction

   // Plays the wrapper: acks bytes after ack_lat cycles (never if <0),
   // offers rx bytes with buffer_ready held high, records what it sees.
   task automatic run_txn(input logic [31:0] w, input logic [31:0] rx,
                          input int ack_lat, input int rfi_delay,
                          input bit extra_start, input int abort_byte,
                          input int max_cyc);
      int cyc, ack_cnt, ri, hi_run, lo_run;
      bit prev_dr, prev_got, da_set, fin, extra_done;
      logic [7:0] prev_bus;
      sent_q.delete(); got_w.delete(); got_g.delete();
      dr_rises = 0; dr_hi = 0; drop_late = 0; bus_unstable = 0;
      done_cnt = 0; first_dr = -1; rfi_cyc = -1;
      ran_out = 0; hit_abort = 0; word_at_done = 'x;
      ack_cnt = 0; ri = 0; hi_run = 0; lo_run = 0;
      prev_dr = 0; prev_got = 0; da_set = 0; fin = 0;
      extra_done = 0; prev_bus = 0;
      data_accepted = 0;
      buffer_ready = 1;
      Bus_in = rx[7:0];
      ready_for_input = (rfi_delay == 0);
      start = 1; word_in = w;
      @(negedge clk);
      start = 0; word_in = $urandom;
      err_at_start = error;
      cyc = 0;
      while (!fin) begin
         if (data_ready) begin
            dr_hi++;
            if (first_dr < 0) first_dr = cyc;
            if (!prev_dr) dr_rises++;
            else if (Bus_out !== prev_bus) bus_unstable++;
         end
         if (da_set && data_ready) drop_late++;
         if (got_data) begin
            if (!prev_got) begin
               if (got_w.size() > 0) got_g.push_back(lo_run);
               hi_run = 0;
               if (ri == abort_byte) begin
                  hit_abort = 1; fin = 1;
               end
               ri++;
               if (ri < NB) Bus_in = rx[8*ri +: 8];
               else buffer_ready = 0;
            end
            hi_run++;
         end else begin
            if (prev_got) begin
               got_w.push_back(hi_run); lo_run = 0;
            end
            lo_run++;
         end
         if (done) begin
            done_cnt++; word_at_done = word_out;
         end
         if (!busy) fin = 1;
         else if (cyc >= max_cyc) begin
            ran_out = 1; fin = 1;
         end
         prev_dr = data_ready; prev_got = got_data; prev_bus = Bus_out;
         if (!fin) begin
            da_set = 0;
            if (!data_accepted && data_ready && ack_lat >= 0) begin
               if (ack_cnt >= ack_lat) begin
                  data_accepted = 1; da_set = 1;
                  sent_q.push_back(Bus_out); ack_cnt = 0;
               end else ack_cnt++;
            end else if (data_accepted && !data_ready)
               data_accepted = 0;
            if (!ready_for_input && cyc >= rfi_delay - 1) begin
               ready_for_input = 1; rfi_cyc = cyc;
            end
            if (extra_start && data_ready && !extra_done) begin
               start = 1; word_in = ~w; extra_done = 1;
            end else start = 0;
            @(negedge clk);
            cyc++;
         end
      end
      start = 0; data_accepted = 0;
      buffer_ready = 0; ready_for_input = 0;
   endtask

   task automatic test_reset();
      rst = 1; start = 1; word_in = $urandom;
      ready_for_input = 1; buffer_ready = 1; Bus_in = 8'hA5;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         total++;
         if ({data_ready, got_data, busy, done, error} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000",
                     {data_ready, got_data, busy, done, error});
         end
         total++;
         if (Bus_out !== 8'h00 || word_out !== 32'h0) begin
            bad++;
            $display("FAIL reset_data: bus=%h word=%h want 0", Bus_out,
                     word_out);
         end
      end
      rst = 0; start = 0;
      ready_for_input = 0; buffer_ready = 0;
      repeat (2) @(negedge clk);
      total++;
      if (busy !== 1'b0 || data_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle: busy=%b dr=%b want 0 0", busy,
                  data_ready);
      end
   endtask

   task automatic test_send_order();
      logic [31:0] w;
      w = 32'h0009_0023;
      run_txn(w, 32'h4433_2211, 0, 0, 0, -1, 2000);
      total++;
      if (sent_bad(w) != 0) begin
         bad++;
         $display("FAIL send_order: got %p want bytes of %h", sent_q, w);
      end
      total++;
      if (dr_rises != NB) begin
         bad++;
         $display("FAIL dr_periods: got %0d want %0d", dr_rises, NB);
      end
      total++;
      if (drop_late != 0 || bus_unstable != 0) begin
         bad++;
         $display("FAIL dr_drop: late=%0d unstable=%0d want 0 0",
                  drop_late, bus_unstable);
      end
      total++;
      if (ran_out != 0 || done_cnt != 1) begin
         bad++;
         $display("FAIL send_done: done=%0d ranout=%0d want 1 0",
                  done_cnt, ran_out);
      end
   endtask

   task automatic test_round_trip();
      logic [31:0] w;
      w = $urandom;
      run_txn(w, 32'h4433_2211, 1, 0, 0, -1, 2000);
      total++;
      if (width_bad() != 0) begin
         bad++;
         $display("FAIL got_width: got %p want %0d x %0d", got_w, NB, GH);
      end
      total++;
      if (gap_bad() != 0) begin
         bad++;
         $display("FAIL got_gap: got %p want >=%0d", got_g, GG);
      end
      total++;
      if (word_at_done !== 32'h4433_2211 || done_cnt != 1) begin
         bad++;
         $display("FAIL round_word: got %h x%0d want 44332211 x1",
                  word_at_done, done_cnt);
      end
      total++;
      if (ran_out != 0 || busy !== 1'b0 || word_out !== 32'h4433_2211)
      begin
         bad++;
         $display("FAIL round_idle: busy=%b word=%h ranout=%0d", busy,
                  word_out, ran_out);
      end
   endtask

   task automatic test_timeout();
      logic [31:0] w;
      logic [31:0] rx;
      w = $urandom;
      run_txn(w, 32'h0102_0304, -1, 0, 0, -1, 600);
      total++;
      if (dr_hi != TO) begin
         bad++;
         $display("FAIL tmo_len: got %0d want %0d", dr_hi, TO);
      end
      total++;
      if (error !== 1'b1 || busy !== 1'b0 || data_ready !== 1'b0 ||
          ran_out != 0) begin
         bad++;
         $display("FAIL tmo_state: err=%b busy=%b dr=%b want 1 0 0",
                  error, busy, data_ready);
      end
      total++;
      if (done_cnt != 0) begin
         bad++;
         $display("FAIL tmo_done: got %0d want 0", done_cnt);
      end
      rx = $urandom;
      run_txn(w, rx, 0, 0, 0, -1, 2000);
      total++;
      if (err_at_start !== 1'b0 || error !== 1'b0) begin
         bad++;
         $display("FAIL tmo_clear: got %b/%b want 0/0", err_at_start,
                  error);
      end
      total++;
      if (word_at_done !== rx) begin
         bad++;
         $display("FAIL tmo_next: got %h want %h", word_at_done, rx);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] w;
      logic [31:0] rx;
      w = $urandom;
      run_txn(w, $urandom, 0, 0, 0, 2, 2000);
      total++;
      if (hit_abort != 1) begin
         bad++;
         $display("FAIL mid_reach: got %0d want 1", hit_abort);
      end
      rst = 1;
      @(negedge clk);
      rst = 0;
      total++;
      if (got_data !== 1'b0 || word_out !== 32'h0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset: got=%b word=%h busy=%b want 0 0 0",
                  got_data, word_out, busy);
      end
      w = $urandom; rx = $urandom;
      run_txn(w, rx, 1, 0, 0, -1, 2000);
      total++;
      if (sent_bad(w) != 0 || word_at_done !== rx || done_cnt != 1) begin
         bad++;
         $display("FAIL mid_fresh: word=%h want %h done=%0d", word_at_done,
                  rx, done_cnt);
      end
   endtask

   task automatic test_busy_start();
      logic [31:0] w;
      logic [31:0] rx;
      int busy_seen;
      w = $urandom; rx = $urandom;
      run_txn(w, rx, 2, 20, 1, -1, 2000);
      total++;
      if (first_dr != rfi_cyc + 1 || rfi_cyc != 19) begin
         bad++;
         $display("FAIL rfi_delay: dr at %0d rfi at %0d want 20 19",
                  first_dr, rfi_cyc);
      end
      total++;
      if (sent_bad(w) != 0 || word_at_done !== rx || done_cnt != 1) begin
         bad++;
         $display("FAIL busy_start: word=%h want %h done=%0d",
                  word_at_done, rx, done_cnt);
      end
      busy_seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (busy !== 1'b0) busy_seen++;
      end
      total++;
      if (busy_seen != 0) begin
         bad++;
         $display("FAIL busy_after: got %0d busy cycles want 0",
                  busy_seen);
      end
   endtask

   task automatic test_random();
      logic [31:0] w;
      logic [31:0] rx;
      for (int n = 0; n < 6; n++) begin
         w = $urandom; rx = $urandom;
         run_txn(w, rx, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 4)), 0, -1, 2000);
         total++;
         if (sent_bad(w) != 0) begin
            bad++;
            $display("FAIL rnd_send %0d: got %p want bytes of %h", n,
                     sent_q, w);
         end
         total++;
         if (word_at_done !== rx || done_cnt != 1 || ran_out != 0) begin
            bad++;
            $display("FAIL rnd_word %0d: got %h want %h done=%0d", n,
                     word_at_done, rx, done_cnt);
         end
         total++;
         if (width_bad() != 0 || gap_bad() != 0 || error !== 1'b0) begin
            bad++;
            $display("FAIL rnd_got %0d: w=%p g=%p err=%b", n, got_w,
                     got_g, error);
         end
      end
   endtask

   initial begin
      rst = 1; start = 0; word_in = '0;
      ready_for_input = 0; data_accepted = 0;
      buffer_ready = 0; Bus_in = '0;
      test_reset();
      test_send_order();
      test_round_trip();
      test_timeout();
      test_reset_mid();
      test_busy_start();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wrapper_host.md
Name: wrapper_host

Overview:
- Host-side peer of the byte-wide wrapper interface. It drives data_ready/Bus and consumes buffer_ready/got_data, which is the opposite end of the wrapper.
- On start, it splits a N_BYTES-byte word into bytes, least-significant byte first, and sends each byte with a 4-phase data_ready/data_accepted handshake.
- It then drains N_BYTES result bytes with got_data pulses while buffer_ready is high, reassembles them into word_out, and pulses done.
- Used as the bench/system-side driver for the wrapper. Includes a handshake timeout.

Parameters:
- N_BYTES, 4, bytes per transaction in each direction.
- GOT_HIGH, 2, cycles got_data is held high per received byte (minimum 1).
- GOT_GAP, 4, low cycles after a got_data pulse before the next byte is sampled (minimum 1).
- TIMEOUT, 255, maximum wait cycles in any handshake wait state; 0 disables the timeout.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a transaction; sampled only in IDLE
- word_in  in  8*N_BYTES  word to send; captured on accepted start
- ready_for_input  in  1  wrapper can accept a new transaction
- data_accepted  in  1  wrapper has latched the current byte
- buffer_ready  in  1  wrapper holds at least one result byte on Bus_in
- Bus_in  in  8  result byte from the wrapper
- data_ready  out  1  Bus_out holds a valid byte
- Bus_out  out  8  byte to the wrapper
- got_data  out  1  current result byte has been taken
- word_out  out  8*N_BYTES  reassembled result; byte 0 is the LSB
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when word_out is valid
- error  out  1  sticky timeout flag; cleared by rst or by an accepted start

Behaviour:
- Reset values: data_ready=0, got_data=0, Bus_out=0, word_out=0, busy=0, done=0, error=0.
  - Reset has priority over every other input and aborts any state to IDLE in the same cycle.
- All outputs are registered.
- Byte index idx counts 0..N_BYTES-1. Transmit byte idx is word_in[8*idx+7:8*idx]. Received byte idx is written to word_out[8*idx+7:8*idx].
- IDLE:
  - start=1 latches word_in into tx_reg, clears idx, clears error, and goes to WAIT_RFI.
  - start while busy is ignored.
- WAIT_RFI:
  - On ready_for_input=1, go to SEND_REQ. Bus_out is loaded with tx byte idx and data_ready=1 in the same registered update.
- SEND_REQ:
  - Hold data_ready=1 with Bus_out stable.
  - On data_accepted=1, drop data_ready next cycle and go to SEND_REL.
- SEND_REL:
  - Wait for data_accepted=0.
  - If idx<N_BYTES-1: increment idx and go back to SEND_REQ, raising data_ready with the next byte immediately.
  - Otherwise clear idx and go to RECV_WAIT.
- RECV_WAIT:
  - On buffer_ready=1, sample Bus_in into word_out byte idx, set got_data=1, and go to RECV_HIGH.
- RECV_HIGH:
  - Hold got_data for GOT_HIGH cycles, then clear it and go to RECV_GAP.
- RECV_GAP:
  - Wait GOT_GAP cycles.
  - If idx<N_BYTES-1: increment idx and go to RECV_WAIT.
  - Otherwise go to DONE.
  - buffer_ready is not sampled during RECV_HIGH or RECV_GAP.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - word_out holds its value until the next transaction overwrites it byte by byte.
- Timeout:
  - A single counter clears on every state change.
  - In WAIT_RFI, SEND_REQ, SEND_REL, or RECV_WAIT, reaching TIMEOUT cycles forces data_ready=0, got_data=0, error=1, and a return to IDLE. done does not pulse.
- Simultaneous events:
  - data_accepted already high on entry to SEND_REQ counts as accepted in that cycle.
  - start and rst together: rst wins.
- Received-byte count is fixed at N_BYTES. Extra buffer_ready after DONE is ignored.

Decomposition:
- Shared package wrapper_pkg: the state enum, BYTE_W=8, and the default N_BYTES, GOT_HIGH, GOT_GAP, TIMEOUT constants.
- One natural sub-module, wrapper_host_cnt: a loadable down-counter with a zero flag. It is reused for the GOT_HIGH/GOT_GAP timing and for the timeout.
- The FSM, shift/index logic and word assembly stay in wrapper_host.

Test Plan:
- Reset then idle:
  - Stimulus: rst high for 2 cycles.
  - Required: all outputs 0 and busy=0. Holding start=1 during rst does not start a transaction.
- Send order with a 1-cycle-ack responder:
  - Stimulus: start with word_in=0x00090023.
  - Required: Bus_out carries 0x23, 0x00, 0x09, 0x00 in that order. Each byte has exactly one data_ready high period, and data_ready falls the cycle after data_accepted.
- Full round trip:
  - Stimulus: responder model returns bytes 0x11, 0x22, 0x33, 0x44 with buffer_ready held high.
  - Required: four got_data pulses of 2 cycles each, separated by at least 4 low cycles. word_out=0x44332211 with a single done pulse, then busy=0.
- Timeout:
  - Stimulus: data_accepted never asserted.
  - Required: after 255 cycles in SEND_REQ, data_ready=0, error=1 and busy=0 with no done. The next start clears error.
- Reset mid-operation:
  - Stimulus: assert rst during RECV_HIGH of byte 2.
  - Required: got_data=0 and word_out=0 on the next edge. A fresh transaction then completes correctly.
- Busy start and delayed ready_for_input:
  - Stimulus: pulse start during SEND_REQ; hold ready_for_input low for 20 cycles before the first transaction.
  - Required: the extra start has no effect. data_ready first rises the cycle after ready_for_input=1.
